// File: rtl/block_dispatcher_if.sv
// Core-side handshake bundle of block_dispatcher: per-core reset/start, block assignment
// and completion. The dispatcher uses the master modport, the core array the slave modport.
interface block_dispatcher_if #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int BLOCK_ID_BITS     = 12
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  logic [NUM_CORES-1:0]     core_start;
  logic [NUM_CORES-1:0]     core_reset;
  logic [NUM_CORES-1:0]     core_done;
  logic [BLOCK_ID_BITS-1:0] core_block_id     [NUM_CORES];
  logic [TCW-1:0]           core_thread_count [NUM_CORES];

  modport master (
    output core_start,
    output core_reset,
    output core_block_id,
    output core_thread_count,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_reset,
    input  core_block_id,
    input  core_thread_count,
    output core_done
  );
endinterface

// File: rtl/block_dispatcher.sv
// Kernel dispatcher: splits thread_count into blocks and hands them to cores via a reset/start
// handshake. Optional BLOCK_DISPATCHER_PERF_EN adds a saturating RUN-cycle counter perf_cycles.
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 16,
  parameter int BLOCK_ID_BITS     = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [THREAD_COUNT_BITS-1:0] thread_count,
  input  logic [NUM_CORES-1:0]         core_enable_mask,
  block_dispatcher_if.master           cores,
  output logic                         busy,
  output logic                         done
`ifdef BLOCK_DISPATCHER_PERF_EN
  ,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int LOG2T = $clog2(THREADS_PER_BLOCK);
  localparam int TCW   = LOG2T + 1;
  localparam int WW    = THREAD_COUNT_BITS + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} top_t;
  typedef enum logic [1:0] {FREE, RST, ACTIVE} core_t;

  top_t                         state_q;
  core_t                        cst_q      [NUM_CORES];
  logic [THREAD_COUNT_BITS-1:0] tc_q;
  logic [WW-1:0]                total_q;
  logic [WW-1:0]                next_q;
  logic [WW-1:0]                completed_q;
  logic                         busy_q;
  logic                         done_q;
  logic [NUM_CORES-1:0]         cstart_q;
  logic [NUM_CORES-1:0]         creset_q;
  logic [BLOCK_ID_BITS-1:0]     bid_q      [NUM_CORES];
  logic [TCW-1:0]               cnt_q      [NUM_CORES];

  logic [WW-1:0]        total_d;
  logic [WW-1:0]        rem_d;
  logic [TCW-1:0]       thr_d;
  logic [WW-1:0]        comp_cnt_d;
  logic [WW-1:0]        completed_d;
  logic [NUM_CORES-1:0] pick_oh_d;
  logic                 pick_any_d;
  logic                 dispatch_d;
  logic                 launch_d;
  logic                 abort_d;

  // Threads in the block being dispatched: a full block unless this is the ragged tail.
  function automatic logic [TCW-1:0] clamp_thr(input logic [WW-1:0] rem);
    if (rem >= WW'(THREADS_PER_BLOCK)) return TCW'(THREADS_PER_BLOCK);
    return rem[TCW-1:0];
  endfunction

  assign total_d     = ({1'b0, thread_count} + WW'(THREADS_PER_BLOCK - 1)) >> LOG2T;
  assign rem_d       = {1'b0, tc_q} - (next_q << LOG2T);
  assign thr_d       = clamp_thr(rem_d);
  assign completed_d = completed_q + comp_cnt_d;
  assign abort_d     = abort && (state_q != IDLE);
  assign launch_d    = start && !abort && (state_q == IDLE || state_q == DONE);
  assign dispatch_d  = (state_q == RUN) && (next_q < total_q) && pick_any_d;

  always_comb begin
    pick_oh_d  = '0;
    pick_any_d = 1'b0;
    comp_cnt_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!pick_any_d && cst_q[i] == FREE && core_enable_mask[i]) begin
        pick_oh_d[i] = 1'b1;
        pick_any_d   = 1'b1;
      end
      if (cst_q[i] == ACTIVE && cores.core_done[i]) comp_cnt_d = comp_cnt_d + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tc_q        <= '0;
      total_q     <= '0;
      next_q      <= '0;
      completed_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cstart_q    <= '0;
      creset_q    <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        cst_q[i] <= FREE;
        bid_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      creset_q <= '0;
      if (abort_d) begin
        // Kill every core, including ones mid-handshake, and return to IDLE.
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        creset_q <= '1;
        cstart_q <= '0;
        for (int i = 0; i < NUM_CORES; i++) cst_q[i] <= FREE;
      end else if (launch_d) begin
        tc_q        <= thread_count;
        total_q     <= total_d;
        next_q      <= '0;
        completed_q <= '0;
        if (thread_count == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
      end else if (state_q == RUN) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          case (cst_q[i])
            FREE: if (dispatch_d && pick_oh_d[i]) begin
              cst_q[i]    <= RST;
              creset_q[i] <= 1'b1;
              bid_q[i]    <= BLOCK_ID_BITS'(next_q);
              cnt_q[i]    <= thr_d;
            end
            RST: begin
              cst_q[i]    <= ACTIVE;
              cstart_q[i] <= 1'b1;
            end
            ACTIVE: if (cores.core_done[i]) begin
              cst_q[i]    <= FREE;
              cstart_q[i] <= 1'b0;
            end
            default: cst_q[i] <= FREE;
          endcase
        end
        if (dispatch_d) next_q <= next_q + WW'(1);
        completed_q <= completed_d;
        if (completed_d == total_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign cores.core_start        = cstart_q;
  assign cores.core_reset        = creset_q;
  assign cores.core_block_id     = bid_q;
  assign cores.core_thread_count = cnt_q;
  assign busy                    = busy_q;
  assign done                    = done_q;

`ifdef BLOCK_DISPATCHER_PERF_EN
  logic [31:0] perf_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                perf_q <= '0;
    else if (launch_d)         perf_q <= '0;
    else if (state_q == RUN)   perf_q <= sat_inc(perf_q);
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: cycle-exact handshake sequences plus a table of
// kernels run to completion against a simple core model that finishes after dly cycles.
module tb_block_dispatcher;

  localparam int NC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] tc;
  logic [1:0]  mask;
  logic        busy;
  logic        done;
  logic [31:0] perf;

  int n_chk = 0;
  int n_err = 0;
  int dly   = 5;

  logic [NC-1:0] done_m;
  int            cnt_m   [NC];
  int            disp_cnt[NC];
  int            act_cnt;
  int            thr_sum;
  int            id_sum;

  block_dispatcher_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(4), .BLOCK_ID_BITS(12)) cif ();

  block_dispatcher #(
    .NUM_CORES(NC), .THREADS_PER_BLOCK(4), .THREAD_COUNT_BITS(16), .BLOCK_ID_BITS(12)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .start            (start),
    .abort            (abort),
    .thread_count     (tc),
    .core_enable_mask (mask),
    .cores            (cif.master),
    .busy             (busy),
    .done             (done)
`ifdef BLOCK_DISPATCHER_PERF_EN
    ,
    .perf_cycles      (perf)
`endif
  );

`ifndef BLOCK_DISPATCHER_PERF_EN
  assign perf = '0;
`endif

  always #5 clk = ~clk;

  assign cif.core_done = done_m;

  // Core model: done rises in the 6th cycle of core_start (dly=5), cleared by core_reset.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (!rst_n || cif.core_reset[i]) begin
        done_m[i] = 1'b0;
        cnt_m[i]  = 0;
      end else if (cif.core_start[i] && !done_m[i]) begin
        cnt_m[i] = cnt_m[i] + 1;
        if (cnt_m[i] > dly) done_m[i] = 1'b1;
      end
    end
    if (cif.core_start != '0 || cif.core_reset != '0) act_cnt++;
    if ($countones(cif.core_reset) == 1) begin
      for (int i = 0; i < NC; i++) begin
        if (cif.core_reset[i]) begin
          disp_cnt[i]++;
          thr_sum += int'(cif.core_thread_count[i]);
          id_sum  += int'(cif.core_block_id[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_mon();
    act_cnt = 0; thr_sum = 0; id_sum = 0;
    for (int i = 0; i < NC; i++) disp_cnt[i] = 0;
  endtask

  typedef struct {
    logic [15:0] tc;
    logic [1:0]  mask;
    int          blocks;
    int          thr;
    int          idsum;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd1,  2'b11, 1, 1,  0};
    vecs[1] = '{16'd4,  2'b11, 1, 4,  0};
    vecs[2] = '{16'd5,  2'b01, 2, 5,  1};
    vecs[3] = '{16'd7,  2'b10, 2, 7,  1};
    vecs[4] = '{16'd9,  2'b11, 3, 9,  3};
    vecs[5] = '{16'd17, 2'b11, 5, 17, 10};
    vecs[6] = '{16'd0,  2'b11, 0, 0,  0};

    done_m = '0;
    for (int i = 0; i < NC; i++) cnt_m[i] = 0;
    clr_mon();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tc = '0; mask = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_start", 32'(cif.core_start), 32'd0);
    chk("rst_creset", 32'(cif.core_reset), 32'd0);
    chk("rst_bid1",  32'(cif.core_block_id[1]), 32'd0);
    chk("rst_perf",  perf, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Kernel of 10 threads across two cores.
    tc = 16'd10; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      case (k)
        1:  begin chk("t1_busy", 32'(busy), 32'd1); chk("t1_reset_k1", 32'(cif.core_reset), 32'd0); end
        2:  begin chk("t1_reset_k2", 32'(cif.core_reset), 32'b01);
                  chk("t1_bid0", 32'(cif.core_block_id[0]), 32'd0);
                  chk("t1_cnt0", 32'(cif.core_thread_count[0]), 32'd4); end
        3:  begin chk("t1_reset_k3", 32'(cif.core_reset), 32'b10);
                  chk("t1_start_k3", 32'(cif.core_start), 32'b01);
                  chk("t1_bid1", 32'(cif.core_block_id[1]), 32'd1);
                  chk("t1_cnt1", 32'(cif.core_thread_count[1]), 32'd4); end
        5:  chk("t1_start_k5", 32'(cif.core_start), 32'b11);
        9:  chk("t1_start_k9", 32'(cif.core_start), 32'b10);
        10: begin chk("t1_reset_k10", 32'(cif.core_reset), 32'b01);
                  chk("t1_bid0_b2", 32'(cif.core_block_id[0]), 32'd2);
                  chk("t1_cnt0_b2", 32'(cif.core_thread_count[0]), 32'd2);
                  chk("t1_start_k10", 32'(cif.core_start), 32'b00); end
        11: chk("t1_start_k11", 32'(cif.core_start), 32'b01);
        16: chk("t1_busydone_k16", {30'd0, busy, done}, 32'b10);
        17: begin chk("t1_busydone_k17", {30'd0, busy, done}, 32'b01);
`ifdef BLOCK_DISPATCHER_PERF_EN
                  chk("t1_perf_k17", perf, 32'd16);
`endif
            end
        20: begin chk("t1_done_hold", 32'(done), 32'd1);
                  chk("t1_bid0_hold", 32'(cif.core_block_id[0]), 32'd2);
`ifdef BLOCK_DISPATCHER_PERF_EN
                  chk("t1_perf_hold", perf, 32'd16);
`endif
            end
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of a kernel.
    tc = 16'd10; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    chk("mr_pre_start", 32'(cif.core_start), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_done",  32'(done), 32'd0);
    chk("mr_start", 32'(cif.core_start), 32'd0);
    chk("mr_bid1",  32'(cif.core_block_id[1]), 32'd0);
    chk("mr_cnt0",  32'(cif.core_thread_count[0]), 32'd0);
    chk("mr_perf",  perf, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-thread kernel touches no core.
    clr_mon();
    tc = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("z_activity", 32'(act_cnt), 32'd0);

    // Mask 10: only core 1 works; masking everything stalls with busy held.
    clr_mon();
    tc = 16'd12; mask = 2'b10; start = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      start = 1'b0;
      case (k)
        1:  chk("m_busy_k1", 32'(busy), 32'd1);
        2:  begin chk("m_reset_k2", 32'(cif.core_reset), 32'b10);
                  chk("m_bid1_b0", 32'(cif.core_block_id[1]), 32'd0); end
        10: begin chk("m_reset_k10", 32'(cif.core_reset), 32'b10);
                  chk("m_bid1_b1", 32'(cif.core_block_id[1]), 32'd1); end
        12: mask = 2'b00;
        20: chk("m_stall_reset", 32'(cif.core_reset), 32'd0);
        25: begin chk("m_stall_busy", {30'd0, busy, done}, 32'b10);
                  chk("m_disp0", 32'(disp_cnt[0]), 32'd0);
                  chk("m_disp1", 32'(disp_cnt[1]), 32'd2);
                  mask = 2'b11; end
        26: begin chk("m_resume_reset", 32'(cif.core_reset), 32'b01);
                  chk("m_bid0_b2", 32'(cif.core_block_id[0]), 32'd2);
                  chk("m_cnt0_b2", 32'(cif.core_thread_count[0]), 32'd4); end
        32: chk("m_done_k32", 32'(done), 32'd0);
        33: chk("m_done_k33", {30'd0, busy, done}, 32'b01);
        default: ;
      endcase
    end

    // Abort with both cores active, then a normal relaunch.
    dly = 50; tc = 16'd16; mask = 2'b11; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      case (k)
        6: begin chk("a_start_pre", 32'(cif.core_start), 32'b11); abort = 1'b1; end
        7: begin abort = 1'b0;
                 chk("a_reset_all", 32'(cif.core_reset), 32'b11);
                 chk("a_start_off", 32'(cif.core_start), 32'b00);
                 chk("a_busydone", {30'd0, busy, done}, 32'b00); end
        8: chk("a_reset_pulse", 32'(cif.core_reset), 32'b00);
        default: ;
      endcase
    end
    dly = 5; tc = 16'd4; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      case (k)
        2: begin chk("ar_reset", 32'(cif.core_reset), 32'b01);
                 chk("ar_cnt0", 32'(cif.core_thread_count[0]), 32'd4); end
        9: chk("ar_done", {30'd0, busy, done}, 32'b01);
        default: ;
      endcase
    end

    // Abort from DONE, then start and abort together in IDLE launches nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ad_reset_all", 32'(cif.core_reset), 32'b11);
    chk("ad_done", 32'(done), 32'd0);
    @(negedge clk);
    clr_mon();
    tc = 16'd8; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("sa_activity", 32'(act_cnt), 32'd0);
    chk("sa_done", 32'(done), 32'd0);

    // Table of kernels run to completion.
    for (int v = 0; v < 7; v++) begin
      bit fin;
      clr_mon();
      dly = 2 + (v % 3);
      tc = vecs[v].tc; mask = vecs[v].mask; start = 1'b1;
      fin = 1'b0;
      for (int k = 0; k < 400 && !fin; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) fin = 1'b1;
      end
      chk($sformatf("v%0d_finished", v), 32'(fin), 32'd1);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_blocks", v), 32'(disp_cnt[0] + disp_cnt[1]), 32'(vecs[v].blocks));
      chk($sformatf("v%0d_threads", v), 32'(thr_sum), 32'(vecs[v].thr));
      chk($sformatf("v%0d_idsum", v), 32'(id_sum), 32'(vecs[v].idsum));
      if (vecs[v].mask == 2'b01) chk($sformatf("v%0d_core1_idle", v), 32'(disp_cnt[1]), 32'd0);
      if (vecs[v].mask == 2'b10) chk($sformatf("v%0d_core0_idle", v), 32'(disp_cnt[0]), 32'd0);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
